rf_dump: RTL

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump.sv | 113 +++++++++++
 1 files changed

// File: rtl/rf_dump.sv
// Register-file dump engine: walks indices FIRST_REG..LAST_REG, reading each
// word through a combinational read port and presenting it on a valid/ready stream.
module rf_dump #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31,
   parameter bit ZERO_R0   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  rf_a,
   input  logic [31:0] rf_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_idx,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_DONE
   } state_t;

   state_t      state;
   logic [4:0]  idx;
   logic [31:0] capture;

   // Register 0 may be hard-wired to zero in the source register file.
   assign capture = (ZERO_R0 && idx == 5'd0) ? 32'd0 : rf_rd;

   // busy is high exactly in READ/SEND, so it doubles as the address select.
   assign rf_a = busy ? idx : FIRST_IDX;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values; blocking writes would create ordering races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= FIRST_IDX;
         out_valid <= 1'b0;
         out_idx   <= 5'd0;
         out_data  <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  idx   <= FIRST_IDX;
                  busy  <= 1'b1;
                  state <= S_READ;
               end
            end

            S_READ: begin
               if (abort) begin
                  state     <= S_IDLE;
                  idx       <= FIRST_IDX;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
               end else begin
                  out_data  <= capture;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
                  state     <= S_SEND;
               end
            end

            S_SEND: begin
               if (abort) begin
                  // The presented word is dropped without a handshake.
                  state     <= S_IDLE;
                  idx       <= FIRST_IDX;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 5'd1;
                     state <= S_READ;
                  end
               end
            end

            S_DONE: begin
               idx   <= FIRST_IDX;
               state <= S_IDLE;
            end

            default: begin
               state     <= S_IDLE;
               idx       <= FIRST_IDX;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
